// File: rtl/stq_adata_sched.sv
// stq_adata_sched: arbitrates four store requesters onto the two stq_adata write ports and tracks written entries
// Ports: clk/rst (sync, active-high); req{0..3}_vld/_WQ/_adata in, req{0..3}_rdy out (combinational grant);
//        wrt{0,1}_en/_WQ/_adata registered write ports; free_en/free_WQ clear a written bit;
//        qry_WQ/qry_written bitmap lookup; occ registered popcount of the bitmap.
// Option: define STQ_ADATA_SCHED_RR_EN for round-robin priority; default is fixed priority req0 > req3.
module stq_adata_sched #(
  parameter int NREQ = 4,
  parameter int WQW  = 6,
  parameter int ADW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_vld,
  input  logic [WQW-1:0] req0_WQ,
  input  logic [ADW-1:0] req0_adata,
  output logic           req0_rdy,
  input  logic           req1_vld,
  input  logic [WQW-1:0] req1_WQ,
  input  logic [ADW-1:0] req1_adata,
  output logic           req1_rdy,
  input  logic           req2_vld,
  input  logic [WQW-1:0] req2_WQ,
  input  logic [ADW-1:0] req2_adata,
  output logic           req2_rdy,
  input  logic           req3_vld,
  input  logic [WQW-1:0] req3_WQ,
  input  logic [ADW-1:0] req3_adata,
  output logic           req3_rdy,
  output logic           wrt0_en,
  output logic [WQW-1:0] wrt0_WQ,
  output logic [ADW-1:0] wrt0_adata,
  output logic           wrt1_en,
  output logic [WQW-1:0] wrt1_WQ,
  output logic [ADW-1:0] wrt1_adata,
  input  logic           free_en,
  input  logic [WQW-1:0] free_WQ,
  input  logic [WQW-1:0] qry_WQ,
  output logic           qry_written,
  output logic [WQW:0]   occ
);
  logic [NREQ-1:0]     w_vld;
  logic [WQW-1:0]      w_wq [NREQ];
  logic [ADW-1:0]      w_ad [NREQ];
  logic [1:0]          w_ptr, w_idx, w_s0, w_s1;
  logic                w_s0_v, w_s1_v;
  logic [NREQ-1:0]     w_gnt;
  logic [2**WQW-1:0]   r_bitmap, w_bm_nxt;
  logic                w_set0, w_set1, w_clr;
  assign w_vld = {req3_vld, req2_vld, req1_vld, req0_vld};
  assign w_wq[0] = req0_WQ;
  assign w_wq[1] = req1_WQ;
  assign w_wq[2] = req2_WQ;
  assign w_wq[3] = req3_WQ;
  assign w_ad[0] = req0_adata;
  assign w_ad[1] = req1_adata;
  assign w_ad[2] = req2_adata;
  assign w_ad[3] = req3_adata;
  // Walk requesters in priority order; slot 1 skips anyone colliding with slot 0's entry.
  always_comb begin
    w_s0_v = 1'b0;
    w_s1_v = 1'b0;
    w_s0   = '0;
    w_s1   = '0;
    w_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = w_ptr + 2'(i);
      if (w_vld[w_idx] && !w_s0_v) begin
        w_s0_v = 1'b1;
        w_s0   = w_idx;
      end else if (w_vld[w_idx] && !w_s1_v && w_wq[w_idx] != w_wq[w_s0]) begin
        w_s1_v = 1'b1;
        w_s1   = w_idx;
      end
    end
  end
  assign w_gnt = rst ? '0 : (NREQ'(w_s0_v) << w_s0) | (NREQ'(w_s1_v) << w_s1);
  assign {req3_rdy, req2_rdy, req1_rdy, req0_rdy} = w_gnt;
`ifdef STQ_ADATA_SCHED_RR_EN
  logic [1:0] r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_s0_v) r_ptr <= (w_s1_v ? w_s1 : w_s0) + 2'd1;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 2'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wrt0_en    <= 1'b0;
      wrt0_WQ    <= '0;
      wrt0_adata <= '0;
      wrt1_en    <= 1'b0;
      wrt1_WQ    <= '0;
      wrt1_adata <= '0;
    end else begin
      wrt0_en <= w_s0_v;
      wrt1_en <= w_s1_v;
      if (w_s0_v) begin
        wrt0_WQ    <= w_wq[w_s0];
        wrt0_adata <= w_ad[w_s0];
      end
      if (w_s1_v) begin
        wrt1_WQ    <= w_wq[w_s1];
        wrt1_adata <= w_ad[w_s1];
      end
    end
  end
  // Count only real bit transitions; a set on the freed entry overrides the free.
  assign w_set0 = wrt0_en && !r_bitmap[wrt0_WQ];
  assign w_set1 = wrt1_en && !r_bitmap[wrt1_WQ] && !(wrt0_en && wrt0_WQ == wrt1_WQ);
  assign w_clr  = free_en && r_bitmap[free_WQ] && !(wrt0_en && wrt0_WQ == free_WQ)
                  && !(wrt1_en && wrt1_WQ == free_WQ);
  always_comb begin
    w_bm_nxt = r_bitmap;
    if (free_en) w_bm_nxt[free_WQ] = 1'b0;
    if (wrt0_en) w_bm_nxt[wrt0_WQ] = 1'b1;
    if (wrt1_en) w_bm_nxt[wrt1_WQ] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitmap <= '0;
      occ      <= '0;
    end else begin
      r_bitmap <= w_bm_nxt;
      occ      <= occ + (WQW+1)'(w_set0) + (WQW+1)'(w_set1) - (WQW+1)'(w_clr);
    end
  end
  assign qry_written = r_bitmap[qry_WQ];
endmodule

// File: tb/tb_stq_adata_sched.sv
// tb_stq_adata_sched: directed checks of arbitration, write ports, bitmap and occupancy
module tb_stq_adata_sched;
  logic       clk, rst;
  logic [3:0] vld;
  logic [5:0] wq [4];
  logic [4:0] ad [4];
  logic [3:0] rdy;
  logic       wrt0_en, wrt1_en, free_en, qry_written;
  logic [5:0] wrt0_WQ, wrt1_WQ, free_WQ, qry_WQ;
  logic [4:0] wrt0_adata, wrt1_adata;
  logic [6:0] occ;
  int         n_tests, n_fail;
  logic       any;
  stq_adata_sched dut (
    .clk(clk), .rst(rst),
    .req0_vld(vld[0]), .req0_WQ(wq[0]), .req0_adata(ad[0]), .req0_rdy(rdy[0]),
    .req1_vld(vld[1]), .req1_WQ(wq[1]), .req1_adata(ad[1]), .req1_rdy(rdy[1]),
    .req2_vld(vld[2]), .req2_WQ(wq[2]), .req2_adata(ad[2]), .req2_rdy(rdy[2]),
    .req3_vld(vld[3]), .req3_WQ(wq[3]), .req3_adata(ad[3]), .req3_rdy(rdy[3]),
    .wrt0_en(wrt0_en), .wrt0_WQ(wrt0_WQ), .wrt0_adata(wrt0_adata),
    .wrt1_en(wrt1_en), .wrt1_WQ(wrt1_WQ), .wrt1_adata(wrt1_adata),
    .free_en(free_en), .free_WQ(free_WQ), .qry_WQ(qry_WQ),
    .qry_written(qry_written), .occ(occ)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    vld = '0;
    free_en = 1'b0;
    free_WQ = '0;
    qry_WQ = '0;
    for (int i = 0; i < 4; i++) begin
      wq[i] = '0;
      ad[i] = '0;
    end
    step;
    vld = 4'b0001;
    #1 chk("rdy_in_reset", 32'(rdy), 32'h0);
    step;
    chk("rst_wrt0", 32'({wrt0_en, wrt0_WQ, wrt0_adata}), 32'h0);
    chk("rst_wrt1", 32'({wrt1_en, wrt1_WQ, wrt1_adata}), 32'h0);
    chk("rst_occ", 32'(occ), 32'h0);
    rst = 1'b0;
    vld = '0;
    for (int i = 0; i < 4; i++) begin
      wq[i] = 6'(i + 1);
      ad[i] = 5'(i + 11);
    end
    vld = 4'hf;
    #1 chk("t1_rdy_c0", 32'(rdy), 32'b0011);
    step;
    vld = 4'b1100;
    #1 chk("t1_rdy_c1", 32'(rdy), 32'b1100);
    chk("t1_wrt0_c1", 32'({wrt0_en, wrt0_WQ, wrt0_adata}), 32'({1'b1, 6'd1, 5'd11}));
    chk("t1_wrt1_c1", 32'({wrt1_en, wrt1_WQ, wrt1_adata}), 32'({1'b1, 6'd2, 5'd12}));
    step;
    vld = '0;
    #1 chk("t1_wrt0_c2", 32'({wrt0_en, wrt0_WQ, wrt0_adata}), 32'({1'b1, 6'd3, 5'd13}));
    chk("t1_wrt1_c2", 32'({wrt1_en, wrt1_WQ, wrt1_adata}), 32'({1'b1, 6'd4, 5'd14}));
    chk("t1_occ_c2", 32'(occ), 32'd2);
    step;
    chk("t1_occ_c3", 32'(occ), 32'd4);
    chk("t1_wrt0_idle", 32'(wrt0_en), 32'd0);
    qry_WQ = 6'd3;
    #1 chk("t1_qry3", 32'(qry_written), 32'd1);
    qry_WQ = 6'd5;
    #1 chk("t1_qry5", 32'(qry_written), 32'd0);
    wq[0] = 6'd7; ad[0] = 5'd5;
    wq[1] = 6'd7; ad[1] = 5'd6;
    vld = 4'b0011;
    #1 chk("t2_rdy_c0", 32'(rdy), 32'b0001);
    step;
    vld = 4'b0010;
    #1 chk("t2_rdy_c1", 32'(rdy), 32'b0010);
    chk("t2_wrt0_c1", 32'({wrt0_en, wrt0_WQ, wrt0_adata}), 32'({1'b1, 6'd7, 5'd5}));
    chk("t2_wrt1_c1", 32'(wrt1_en), 32'd0);
    step;
    vld = '0;
    #1 chk("t2_wrt0_c2", 32'({wrt0_en, wrt0_WQ, wrt0_adata}), 32'({1'b1, 6'd7, 5'd6}));
    chk("t2_occ_c2", 32'(occ), 32'd5);
    step;
    chk("t2_occ_c3", 32'(occ), 32'd5);
    wq[0] = 6'd8; ad[0] = 5'd1;
    wq[1] = 6'd9; ad[1] = 5'd2;
    vld = 4'b0011;
    #1 chk("t3_rdy_a", 32'(rdy), 32'b0011);
    step;
    vld = '0;
    step;
    chk("t3_occ_a", 32'(occ), 32'd7);
    wq[0] = 6'd10; ad[0] = 5'd3;
    wq[1] = 6'd9;  ad[1] = 5'd4;
    vld = 4'b0011;
    step;
    vld = '0;
    free_en = 1'b1;
    free_WQ = 6'd9;
    #1 chk("t3_wrt1", 32'({wrt1_en, wrt1_WQ, wrt1_adata}), 32'({1'b1, 6'd9, 5'd4}));
    step;
    free_en = 1'b0;
    qry_WQ = 6'd9;
    #1 chk("t3_qry9", 32'(qry_written), 32'd1);
    chk("t3_occ_b", 32'(occ), 32'd8);
    wq[3] = 6'd15; ad[3] = 5'd7;
    vld = 4'b1000;
    #1 chk("t4_rdy_r3", 32'(rdy), 32'b1000);
    step;
    for (int i = 0; i < 4; i++) wq[i] = 6'(16 + i);
    vld = 4'hf;
    #1 chk("t4_rdy_all", 32'(rdy), 32'b0011);
    step;
    wq[0] = 6'd20;
    wq[1] = 6'd21;
`ifdef STQ_ADATA_SCHED_RR_EN
    #1 chk("t4_rdy_round2", 32'(rdy), 32'b1100);
`else
    #1 chk("t4_rdy_round2", 32'(rdy), 32'b0011);
`endif
    step;
    chk("t5_pre_wrt0", 32'(wrt0_en), 32'd1);
    rst = 1'b1;
    #1 chk("t5_rdy_rst", 32'(rdy), 32'h0);
    step;
    rst = 1'b0;
    vld = '0;
    #1 chk("t5_wrt0_en", 32'(wrt0_en), 32'd0);
    chk("t5_wrt1_en", 32'(wrt1_en), 32'd0);
    chk("t5_occ", 32'(occ), 32'd0);
    any = 1'b0;
    for (int i = 0; i < 64; i++) begin
      qry_WQ = 6'(i);
      #1 any = any | qry_written;
    end
    chk("t5_bitmap_clear", 32'(any), 32'd0);
    step;
    for (int k = 0; k < 32; k++) begin
      wq[0] = 6'(2 * k);     ad[0] = 5'(k);
      wq[1] = 6'(2 * k + 1); ad[1] = 5'(k + 1);
      vld = 4'b0011;
      #1 chk($sformatf("t6_rdy_%0d", k), 32'(rdy), 32'b0011);
      step;
    end
    vld = '0;
    #1 chk("t6_occ_62", 32'(occ), 32'd62);
    step;
    chk("t6_occ_64", 32'(occ), 32'd64);
    free_en = 1'b1;
    free_WQ = 6'd63;
    step;
    free_en = 1'b0;
    #1 chk("t6_occ_63", 32'(occ), 32'd63);
    qry_WQ = 6'd63;
    #1 chk("t6_qry63", 32'(qry_written), 32'd0);
    qry_WQ = 6'd62;
    #1 chk("t6_qry62", 32'(qry_written), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
